muldiv_seq: RTL and testbench
=============================

# muldiv_seq

Iterative multiply/divide sequencer for the RV32M extension in the pipelined core. It sits beside the EX-stage ALU and accepts one M-type operation: `mul`, `mulh`, `mulhsu`, `mulhu`, `div`, `divu`, `rem` or `remu`. It runs the operation through a shared 32-step shift-add / restoring-divide datapath. While the operation runs it raises a stall request to the hazard unit, then presents a one-cycle result to the EX/MEM register.

## Interface
- `XLEN`, default 32: operand and result width. Only 32 is supported.
- `i_clk` in 1: single clock. All state updates on the rising edge.
- `i_rst_n` in 1: reset. Synchronous, active-low.
- `i_start` in 1: EX stage holds a valid M-type instruction. Held high while stalled.
- `i_md_op` in 3: funct3 encoding.
  - 000 `mul`, 001 `mulh`, 010 `mulhsu`, 011 `mulhu`
  - 100 `div`, 101 `divu`, 110 `rem`, 111 `remu`
- `i_rs1_data` in 32: operand A (multiplicand / dividend).
- `i_rs2_data` in 32: operand B (multiplier / divisor).
- `i_kill` in 1: flush of the EX stage. Aborts any operation in flight.
- `o_busy` out 1: stall request to the hazard unit. Freezes IF/ID/EX.
- `o_valid` out 1: one-cycle pulse. `o_result` is valid in that cycle.
- `o_result` out 32: registered result. Holds its value until the next completion.

## Operation
- FSM states are IDLE, CALC and DONE. A 5-bit step counter runs inside CALC.
- IDLE:
  - `i_start`=1 and `i_kill`=0 accepts the operation. Latch `i_md_op`, the operand magnitudes and the result-sign flags.
  - Normal path: counter←0, go to CALC.
  - Shortcut cases go directly to DONE:
    - Divide/rem by zero: quotient 0xFFFFFFFF; remainder = dividend, unmodified.
    - Signed overflow (`div`/`rem` with 0x80000000 / 0xFFFFFFFF): quotient 0x80000000; remainder 0.
- CALC: one iteration per cycle.
  - Multiply: 64-bit product register, shift-add.
  - Divide: restoring shift-subtract on a 32-bit remainder and 32-bit quotient.
  - When counter==31, go to DONE. Otherwise counter+1.
- DONE: apply final sign correction, register `o_result`, assert `o_valid` for this cycle, then return to IDLE.
  - `i_start` is ignored in DONE. It still belongs to the completing instruction.
- Signedness:
  - `mul`/`mulh`: both operands signed.
  - `mulhsu`: rs1 signed, rs2 unsigned.
  - `mulhu`/`divu`/`remu`: both unsigned.
  - `div`/`rem`: both signed.
  - Signed operands are converted to magnitude on acceptance.
  - Product is negated if exactly one signed operand is negative.
  - Quotient is negated if the dividend and divisor signs differ.
  - Remainder takes the sign of the dividend.
- Result select: `mul` takes product[31:0]; `mulh*` takes product[63:32]; `div*` takes the quotient; `rem*` takes the remainder.
- `o_busy` is combinational: (IDLE & `i_start` & ~`i_kill`) | CALC. It is 0 in DONE so the pipeline advances with the result.
- `i_kill`:
  - In any state, the next state is IDLE and the counter clears.
  - `o_valid` is forced 0 in that cycle.
  - `o_result` is not updated.
  - `i_kill` has priority over `i_start` in the same cycle.
- Reset (`i_rst_n`=0 at an edge): state IDLE, counter 0, `o_result` 0x00000000, `o_valid` 0, all internal registers cleared.
  - `o_busy` is forced 0 while `i_rst_n`=0.
  - Reset mid-operation discards the operation silently.

## Timing
- The accept cycle is T0 (IDLE, `i_start`=1).
- Normal path:
  - CALC occupies T1..T32.
  - DONE is T33: `o_valid`=1 and `o_result` is valid.
  - `o_busy`=1 during T0..T32 and 0 at T33.
  - Latency is 33 cycles. Throughput is one operation per 34 cycles, because a back-to-back start is accepted at T34 in IDLE.
- Shortcut path: DONE at T1, `o_valid`=1 at T1, `o_busy`=1 only at T0.
- Operands are sampled only at T0. Changes on `i_rs*_data` after T0 have no effect.
- `o_result` changes only on the edge entering DONE.

## Test plan
- `mul` rs1=7, rs2=0xFFFFFFFD (-3), `i_start` held → `o_busy` high T0..T32, `o_valid` at T33, `o_result`=0xFFFFFFEB. `mulhu` with the same operands → 0x00000006.
- `mulh` 0x80000000 × 0x80000000 → 0x40000000. `mulhsu` 0xFFFFFFFF × 0xFFFFFFFF → 0xFFFFFFFF. Each with `o_valid` at T33.
- `div` 0xFFFFFFF9 (-7) / 2 → 0xFFFFFFFD. `rem` with the same operands → 0xFFFFFFFF. `divu` 100/7 → 14. `remu` 100/7 → 2.
- `divu` 5/0 → 0xFFFFFFFF, `o_valid` at T1. `rem` 5/0 → 5. `div` 0x80000000/0xFFFFFFFF → 0x80000000. `rem` with the same operands → 0, `o_valid` at T1.
- Start `mul` 3×4, then assert `i_kill` at T10 → IDLE at T11, no `o_valid` pulse, `o_result` unchanged. Start `mul` 5×6 at T11 → 30, `o_valid` at T44.
- Pull `i_rst_n` low at T15 of a `div` → all outputs 0 the next cycle. After release, a new `divu` 9/3 → 3 with normal 33-cycle latency.

Source files
------------

// File: rtl/muldiv_seq.sv
// Iterative RV32M multiply/divide unit: 32-step shift-add / restoring divide on one
// 64-bit accumulator, with stall request and a one-cycle result pulse.
module muldiv_seq #(
  parameter int XLEN = 32
) (
  input  logic            i_clk,
  input  logic            i_rst_n,
  input  logic            i_start,
  input  logic [2:0]      i_md_op,
  input  logic [XLEN-1:0] i_rs1_data,
  input  logic [XLEN-1:0] i_rs2_data,
  input  logic            i_kill,
  output logic            o_busy,
  output logic            o_valid,
  output logic [XLEN-1:0] o_result
);

  // state | meaning
  // IDLE  | waiting for an M-type op; accepts on i_start
  // CALC  | one shift-add / shift-subtract step per cycle, 32 steps
  // DONE  | o_result registered, o_valid pulses
  typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

  localparam logic [XLEN-1:0] ALL_ONES = {XLEN{1'b1}};
  localparam logic [XLEN-1:0] INT_MIN  = {1'b1, {(XLEN-1){1'b0}}};

  state_t            state;
  logic [4:0]        cnt;
  logic [2:0]        op_r;
  logic              neg_main;
  logic              neg_rem;
  logic [XLEN-1:0]   opnd;
  logic [2*XLEN-1:0] acc;
  logic              valid_r;

  logic              a_sgn, b_sgn;
  logic [XLEN-1:0]   a_mag, b_mag;
  logic              div_zero, div_ovf;

  always_comb begin
    a_sgn = 1'b0;
    b_sgn = 1'b0;
    case (i_md_op)
      3'b000, 3'b001, 3'b100, 3'b110: begin
        a_sgn = i_rs1_data[XLEN-1];
        b_sgn = i_rs2_data[XLEN-1];
      end
      3'b010:  a_sgn = i_rs1_data[XLEN-1];
      default: ;
    endcase
    a_mag    = a_sgn ? -i_rs1_data : i_rs1_data;
    b_mag    = b_sgn ? -i_rs2_data : i_rs2_data;
    div_zero = i_md_op[2] && (i_rs2_data == '0);
    div_ovf  = i_md_op[2] && !i_md_op[0] && (i_rs1_data == INT_MIN) && (i_rs2_data == ALL_ONES);
  end

  // acc holds the product for multiplies, {remainder, quotient} for divides
  logic [XLEN:0]     sum;
  logic [XLEN:0]     shifted;
  logic [XLEN-1:0]   diff;
  logic              ge;
  logic [2*XLEN-1:0] acc_nxt;

  always_comb begin
    sum     = '0;
    shifted = '0;
    diff    = '0;
    ge      = 1'b0;
    if (!op_r[2]) begin
      sum     = {1'b0, acc[2*XLEN-1:XLEN]} + (acc[0] ? {1'b0, opnd} : '0);
      acc_nxt = {sum, acc[XLEN-1:1]};
    end else begin
      shifted = acc[2*XLEN-1:XLEN-1];
      ge      = shifted >= {1'b0, opnd};
      diff    = shifted[XLEN-1:0] - opnd;
      acc_nxt = {(ge ? diff : shifted[XLEN-1:0]), acc[XLEN-2:0], ge};
    end
  end

  logic [2*XLEN-1:0] prod_s;
  logic [XLEN-1:0]   quo_s, rem_s, res_calc;

  always_comb begin
    prod_s = neg_main ? -acc_nxt : acc_nxt;
    quo_s  = neg_main ? -acc_nxt[XLEN-1:0] : acc_nxt[XLEN-1:0];
    rem_s  = neg_rem ? -acc_nxt[2*XLEN-1:XLEN] : acc_nxt[2*XLEN-1:XLEN];
    if (!op_r[2])
      res_calc = (op_r[1:0] == 2'b00) ? prod_s[XLEN-1:0] : prod_s[2*XLEN-1:XLEN];
    else
      res_calc = op_r[1] ? rem_s : quo_s;
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      state    <= IDLE;
      cnt      <= '0;
      op_r     <= '0;
      neg_main <= 1'b0;
      neg_rem  <= 1'b0;
      opnd     <= '0;
      acc      <= '0;
      valid_r  <= 1'b0;
      o_result <= '0;
    end else begin
      valid_r <= 1'b0;
      if (i_kill) begin
        state <= IDLE;
        cnt   <= '0;
      end else begin
        case (state)
          IDLE: if (i_start) begin
            op_r     <= i_md_op;
            neg_main <= a_sgn ^ b_sgn;
            neg_rem  <= a_sgn;
            if (div_zero) begin
              o_result <= i_md_op[1] ? i_rs1_data : ALL_ONES;
              valid_r  <= 1'b1;
              state    <= DONE;
            end else if (div_ovf) begin
              o_result <= i_md_op[1] ? '0 : INT_MIN;
              valid_r  <= 1'b1;
              state    <= DONE;
            end else begin
              acc   <= {{XLEN{1'b0}}, (i_md_op[2] ? a_mag : b_mag)};
              opnd  <= i_md_op[2] ? b_mag : a_mag;
              cnt   <= '0;
              state <= CALC;
            end
          end
          CALC: begin
            acc <= acc_nxt;
            if (cnt == 5'd31) begin
              o_result <= res_calc;
              valid_r  <= 1'b1;
              state    <= DONE;
            end else begin
              cnt <= cnt + 5'd1;
            end
          end
          DONE:    state <= IDLE;
          default: state <= IDLE;
        endcase
      end
    end
  end

  assign o_busy  = i_rst_n && (((state == IDLE) && i_start && !i_kill) || (state == CALC));
  assign o_valid = valid_r && !i_kill;

endmodule

// File: tb/tb_muldiv_seq.sv
// Bench for muldiv_seq: directed RV32M vectors, scoreboard of expected results and
// completion cycles, checked by an independent monitor on o_valid.
module tb_muldiv_seq;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start;
  logic [2:0]  md_op;
  logic [31:0] rs1, rs2;
  logic        kill;
  logic        busy, valid;
  logic [31:0] result;

  muldiv_seq #(.XLEN(32)) dut (
    .i_clk(clk), .i_rst_n(rst_n), .i_start(start), .i_md_op(md_op),
    .i_rs1_data(rs1), .i_rs2_data(rs2), .i_kill(kill),
    .o_busy(busy), .o_valid(valid), .o_result(result)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [31:0] res;
    int          at;
  } exp_t;
  exp_t sb[$];

  int n_checks = 0;
  int n_pass   = 0;
  logic [31:0] last_res;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
  endtask

  // Monitor: every o_valid pulse must match the oldest outstanding expectation
  always @(negedge clk) begin
    if (valid === 1'b1) begin
      n_checks++;
      if (sb.size() == 0) begin
        $display("FAIL unexpected_valid: got result %h with no op pending (cycle %0d)", result, cyc);
      end else begin
        exp_t e;
        e = sb.pop_front();
        if (result === e.res && cyc == e.at) n_pass++;
        else $display("FAIL result: got %h at cycle %0d expected %h at cycle %0d",
                      result, cyc, e.res, e.at);
      end
    end
  end

  // Called at #1 after a rising edge; returns at #1 after the edge leaving DONE.
  task automatic do_op(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                       input logic [31:0] exp, input int lat);
    start = 1'b1;
    md_op = op;
    rs1   = a;
    rs2   = b;
    sb.push_back('{exp, cyc + lat});
    for (int k = 0; k <= lat; k++) begin
      @(negedge clk);
      chk("busy", {31'b0, busy}, {31'b0, (k < lat)});
      if (k == 0) chk("result_hold", result, last_res);
      @(posedge clk);
      #1;
      if (k == 0) begin
        rs1 = ~a;
        rs2 = a ^ 32'h5a5a_5a5a;
      end
    end
    start    = 1'b0;
    last_res = exp;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got cycle %0d expected < 20000", cyc);
    $fatal(1);
  end

  initial begin
    rst_n = 1'b0; start = 1'b1; md_op = 3'b000; rs1 = 32'd1; rs2 = 32'd1; kill = 1'b0;
    last_res = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("reset_busy", {31'b0, busy}, 32'd0);
    chk("reset_valid", {31'b0, valid}, 32'd0);
    chk("reset_result", result, 32'd0);
    @(posedge clk); #1;
    start = 1'b0; rst_n = 1'b1;
    @(posedge clk); #1;

    do_op(3'b000, 32'd7,        32'hFFFF_FFFD, 32'hFFFF_FFEB, 33);
    do_op(3'b011, 32'd7,        32'hFFFF_FFFD, 32'h0000_0006, 33);
    do_op(3'b001, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 33);
    do_op(3'b010, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 33);
    do_op(3'b001, 32'hFFFF_FFFF, 32'd2,        32'hFFFF_FFFF, 33);
    do_op(3'b100, 32'hFFFF_FFF9, 32'd2,        32'hFFFF_FFFD, 33);
    do_op(3'b110, 32'hFFFF_FFF9, 32'd2,        32'hFFFF_FFFF, 33);
    do_op(3'b100, 32'hFFFF_FFF9, 32'hFFFF_FFFE, 32'd3,        33);
    do_op(3'b110, 32'hFFFF_FFF9, 32'hFFFF_FFFE, 32'hFFFF_FFFF, 33);
    do_op(3'b101, 32'd100,      32'd7,        32'd14,       33);
    do_op(3'b111, 32'd100,      32'd7,        32'd2,        33);
    do_op(3'b101, 32'd5,        32'd0,        32'hFFFF_FFFF, 1);
    do_op(3'b110, 32'd5,        32'd0,        32'd5,        1);
    do_op(3'b100, 32'hFFFF_FFFB, 32'd0,        32'hFFFF_FFFF, 1);
    do_op(3'b110, 32'hFFFF_FFFB, 32'd0,        32'hFFFF_FFFB, 1);
    do_op(3'b100, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 1);
    do_op(3'b110, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0,        1);

    // Kill at T10 of a mul: no pulse, result untouched, next op accepted at T11
    start = 1'b1; md_op = 3'b000; rs1 = 32'd3; rs2 = 32'd4;
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      chk("kill_busy", {31'b0, busy}, 32'd1);
      @(posedge clk); #1;
    end
    kill = 1'b1;
    @(negedge clk);
    chk("kill_valid", {31'b0, valid}, 32'd0);
    @(posedge clk); #1;
    kill = 1'b0;
    do_op(3'b000, 32'd5, 32'd6, 32'd30, 33);

    // Reset at T15 of a div: silently discarded, outputs cleared
    start = 1'b1; md_op = 3'b100; rs1 = 32'd100; rs2 = 32'd7;
    for (int k = 0; k < 15; k++) begin
      @(negedge clk);
      chk("rst_mid_busy", {31'b0, busy}, 32'd1);
      @(posedge clk); #1;
    end
    rst_n = 1'b0; start = 1'b0;
    @(negedge clk);
    chk("rst_busy_forced", {31'b0, busy}, 32'd0);
    @(posedge clk); #1;
    @(negedge clk);
    chk("rst_after_busy", {31'b0, busy}, 32'd0);
    chk("rst_after_valid", {31'b0, valid}, 32'd0);
    chk("rst_after_result", result, 32'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    last_res = '0;
    do_op(3'b101, 32'd9, 32'd3, 32'd3, 33);

    repeat (5) @(posedge clk);
    #1;
    chk("sb_drained", sb.size(), 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
